// File: rtl/qs_pkg.sv
// qs_pkg
//   Shared parameters, types and small helpers for the quicksort unit.
//   N       : words per bank (power of 2)
//   W       : data word width
//   BANK_N  : number of banks (power of 2, at least 2)
//   n_t     : word count, wide enough to hold N exactly
//   addr_t  : word address inside one bank
//   bank_n_t: bank index
package qs_pkg;

  localparam int N      = 16;
  localparam int W      = 32;
  localparam int BANK_N = 2;

  localparam int ADDR_W = $clog2(N);
  localparam int BANK_W = $clog2(BANK_N);

  typedef logic [ADDR_W:0]   n_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [W-1:0]      w_t;
  typedef logic [BANK_W-1:0] bank_n_t;

  // Life cycle of one bank as tracked by the bank controller.
  typedef enum logic [2:0] {
    BANK_IDLE    = 3'd0,
    BANK_LOADING = 3'd1,
    BANK_READY   = 3'd2,
    BANK_SORTING = 3'd3,
    BANK_DONE    = 3'd4
  } bank_status_t;

  // Bit 0 of the encoding doubles as the busy flag.
  typedef enum logic [2:0] {
    ENQ_IDLE = 3'b000,
    ENQ_LOAD = 3'b101
  } enqueue_fsm_t;

  localparam int ENQUEUE_FSM_BUSY_B = 0;

  // One-hot flag vector selecting bank b.
  function automatic logic [BANK_N-1:0] bank_onehot(input bank_n_t b);
    logic [BANK_N-1:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Status field of bank b out of the packed 3-bits-per-bank vector.
  function automatic bank_status_t bank_status_of(input logic [3*BANK_N-1:0] v,
                                                  input bank_n_t b);
    return bank_status_t'(v[3*b +: 3]);
  endfunction

endpackage

// File: rtl/qs_enqueue.sv
// qs_enqueue
//   Front-end load engine of the quicksort unit. Picks banks round-robin,
//   waits for the selected bank to be idle, then streams one last-delimited
//   packet into it at consecutive addresses and reports count/overflow.
//   clk, rst                  : clock, asynchronous active-high reset
//   in_vld/in_w/in_last/in_rdy: input word stream (valid/ready)
//   bank_status_i             : bank_status_t per bank, bank b at [3b+2:3b]
//   load_start_o              : one-hot pulse, bank begins loading
//   load_done_o               : one-hot pulse, bank load complete
//   load_n_o, load_err_o      : word count and overflow, valid with done
//   wr_en_o/wr_bank_o/wr_addr_o/wr_data_o : bank memory write port
//   busy_o                    : engine is loading a bank
module qs_enqueue
  import qs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  w_t                  in_w,
  input  logic                in_last,
  output logic                in_rdy,
  input  logic [3*BANK_N-1:0] bank_status_i,
  output logic [BANK_N-1:0]   load_start_o,
  output logic [BANK_N-1:0]   load_done_o,
  output n_t                  load_n_o,
  output logic                load_err_o,
  output logic                wr_en_o,
  output bank_n_t             wr_bank_o,
  output addr_t               wr_addr_o,
  output w_t                  wr_data_o,
  output logic                busy_o
);

  enqueue_fsm_t      state_q;
  bank_n_t           ptr_q;
  n_t                cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [BANK_N-1:0] loadStart_q;
  logic [BANK_N-1:0] loadDone_q;
  n_t                loadN_q;
  logic              loadErr_q;
  logic              accept;
  logic              full;

  assign in_rdy = (state_q == ENQ_LOAD);
  assign accept = in_vld & in_rdy;
  assign full   = (cnt_q == n_t'(N));

  // Write port is driven straight from the accepted beat so the word lands
  // in the bank in the same cycle. Beats past a full bank are swallowed and
  // only mark the overflow.
  always_comb begin
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_en_o   = 1'b0;
    wr_bank_o = '0;
    wr_addr_o = '0;
    wr_data_o = '0;
    if (accept) begin
      if (!full) begin
        wr_en_o   = 1'b1;
        wr_bank_o = ptr_q;
        wr_addr_o = cnt_q[ADDR_W-1:0];
        wr_data_o = in_w;
        cnt_d     = cnt_q + n_t'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Enqueue FSM with its registered pulses. The start/done pulses and the
  // count/error report default to zero every cycle so each lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ENQ_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      loadStart_q <= '0;
      loadDone_q  <= '0;
      loadN_q     <= '0;
      loadErr_q   <= 1'b0;
    end else begin
      loadStart_q <= '0;
      loadDone_q  <= '0;
      loadN_q     <= '0;
      loadErr_q   <= 1'b0;
      unique case (state_q)
        ENQ_IDLE: begin
          // Strict round-robin: wait on the current bank, never skip ahead.
          if (bank_status_of(bank_status_i, ptr_q) == BANK_IDLE) begin
            loadStart_q <= bank_onehot(ptr_q);
            cnt_q       <= '0;
            err_q       <= 1'b0;
            state_q     <= ENQ_LOAD;
          end
        end
        ENQ_LOAD: begin
          cnt_q <= cnt_d;
          err_q <= err_d;
          if (accept && in_last) begin
            loadDone_q <= bank_onehot(ptr_q);
            loadN_q    <= cnt_d;
            loadErr_q  <= err_d;
            ptr_q      <= ptr_q + bank_n_t'(1);
            state_q    <= ENQ_IDLE;
          end
        end
        default: state_q <= ENQ_IDLE;
      endcase
    end
  end

  assign load_start_o = loadStart_q;
  assign load_done_o  = loadDone_q;
  assign load_n_o     = loadN_q;
  assign load_err_o   = loadErr_q;
  assign busy_o       = state_q[ENQUEUE_FSM_BUSY_B];

endmodule

// File: tb/tb_qs_enqueue.sv
// tb_qs_enqueue
//   Packet-level bench for qs_enqueue. Each packet is described by its length,
//   how long its bank stays busy before becoming idle, and an optional reset
//   point. Expected writes, counts and flags follow from the packet alone.
module tb_qs_enqueue;
  import qs_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_vld;
  w_t                  in_w;
  logic                in_last;
  logic                in_rdy;
  logic [3*BANK_N-1:0] bankStatus;
  logic [BANK_N-1:0]   load_start_o;
  logic [BANK_N-1:0]   load_done_o;
  n_t                  load_n_o;
  logic                load_err_o;
  logic                wr_en_o;
  bank_n_t             wr_bank_o;
  addr_t               wr_addr_o;
  w_t                  wr_data_o;
  logic                busy_o;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference state: next bank in round-robin order and the report owed
  // by the packet that just finished.
  int modelPtr    = 0;
  bit pendingDone = 1'b0;
  int pendBank    = 0;
  int pendN       = 0;
  bit pendErr     = 1'b0;

  always #5 clk = ~clk;

  qs_enqueue dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld       (in_vld),
    .in_w         (in_w),
    .in_last      (in_last),
    .in_rdy       (in_rdy),
    .bank_status_i(bankStatus),
    .load_start_o (load_start_o),
    .load_done_o  (load_done_o),
    .load_n_o     (load_n_o),
    .load_err_o   (load_err_o),
    .wr_en_o      (wr_en_o),
    .wr_bank_o    (wr_bank_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BANK_N-1:0] ohBank(input int b);
    logic [BANK_N-1:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Drive the target bank to a fixed status; all other banks get noise.
  task automatic driveStatus(input int target, input bank_status_t s);
    for (int b = 0; b < BANK_N; b++) begin
      if (b == target) bankStatus[3*b +: 3] = s;
      else             bankStatus[3*b +: 3] = 3'($urandom_range(0, 4));
    end
  endtask

  task automatic resetDut(input bit keepVld);
    rst        = 1'b1;
    in_vld     = keepVld;
    bankStatus = {BANK_N{BANK_SORTING}};
    #1;
    checkOutput("rst_start", 64'(load_start_o), 64'(0));
    checkOutput("rst_done",  64'(load_done_o),  64'(0));
    checkOutput("rst_n",     64'(load_n_o),     64'(0));
    checkOutput("rst_err",   64'(load_err_o),   64'(0));
    checkOutput("rst_wr_en", 64'(wr_en_o),      64'(0));
    checkOutput("rst_wr_bk", 64'(wr_bank_o),    64'(0));
    checkOutput("rst_wr_ad", 64'(wr_addr_o),    64'(0));
    checkOutput("rst_wr_dt", 64'(wr_data_o),    64'(0));
    checkOutput("rst_rdy",   64'(in_rdy),       64'(0));
    checkOutput("rst_busy",  64'(busy_o),       64'(0));
    @(negedge clk);
    @(negedge clk);
    rst         = 1'b0;
    in_vld      = 1'b0;
    modelPtr    = 0;
    pendingDone = 1'b0;
  endtask

  // One packet: report slot of the previous packet, wait for the bank,
  // then stream len beats with random valid gaps.
  task automatic applyStimulus(input int len, input int holdoff,
                               input int abortAfter, input bit seqData);
    int  eb;
    int  idx;
    int  guard;
    bit  vld;
    eb = modelPtr;

    @(negedge clk);
    in_vld  = 1'b0;
    in_last = 1'b0;
    driveStatus(eb, (holdoff == 0) ? BANK_IDLE : BANK_SORTING);
    #2;
    checkOutput("done",      64'(load_done_o), pendingDone ? 64'(ohBank(pendBank)) : 64'(0));
    checkOutput("done_n",    64'(load_n_o),    pendingDone ? 64'(pendN) : 64'(0));
    checkOutput("done_err",  64'(load_err_o),  pendingDone ? 64'(pendErr) : 64'(0));
    checkOutput("done_rdy",  64'(in_rdy),      64'(0));
    checkOutput("done_busy", 64'(busy_o),      64'(0));
    checkOutput("done_strt", 64'(load_start_o), 64'(0));
    pendingDone = 1'b0;

    for (int i = 0; i <= holdoff; i++) begin
      @(negedge clk);
      checkOutput("start", 64'(load_start_o), (i == holdoff) ? 64'(ohBank(eb)) : 64'(0));
      if (i == holdoff) break;
      checkOutput("wait_rdy",  64'(in_rdy),      64'(0));
      checkOutput("wait_done", 64'(load_done_o), 64'(0));
      in_vld  = 1'($urandom_range(0, 1));
      in_w    = W'($urandom);
      in_last = 1'($urandom_range(0, 1));
      driveStatus(eb, (i + 1 >= holdoff) ? BANK_IDLE : BANK_SORTING);
      #2;
      checkOutput("wait_wr", 64'(wr_en_o), 64'(0));
    end

    idx   = 0;
    guard = 0;
    while (1) begin
      if (guard > 0) @(negedge clk);
      guard++;
      if (guard > 1000) begin
        checkOutput("load_timeout", 64'(idx), 64'(len));
        break;
      end
      driveStatus(-1, BANK_IDLE);
      vld     = ($urandom_range(0, 3) != 0);
      in_vld  = vld;
      in_w    = seqData ? W'(32'hA0 + 32'(idx)) : W'($urandom);
      in_last = vld ? (idx == len - 1) : 1'($urandom_range(0, 1));
      #2;
      checkOutput("load_rdy",  64'(in_rdy),      64'(1));
      checkOutput("load_busy", 64'(busy_o),      64'(1));
      checkOutput("load_done", 64'(load_done_o), 64'(0));
      if (guard > 1) checkOutput("load_strt", 64'(load_start_o), 64'(0));
      if (vld && idx < N) begin
        checkOutput("wr_en",   64'(wr_en_o),   64'(1));
        checkOutput("wr_bank", 64'(wr_bank_o), 64'(eb));
        checkOutput("wr_addr", 64'(wr_addr_o), 64'(idx));
        checkOutput("wr_data", 64'(wr_data_o), 64'(in_w));
      end else begin
        checkOutput("wr_idle", 64'(wr_en_o), 64'(0));
      end
      if (vld) begin
        idx++;
        if (abortAfter != 0 && idx == abortAfter) begin
          #1;
          resetDut(1'b1);
          return;
        end
        if (idx == len) break;
      end
    end

    pendingDone = 1'b1;
    pendBank    = eb;
    pendN       = (len < N) ? len : N;
    pendErr     = (len > N);
    modelPtr    = (eb + 1) % BANK_N;
  endtask

  // Report slot of the final packet.
  task automatic flushReport();
    @(negedge clk);
    in_vld = 1'b0;
    #2;
    checkOutput("last_done", 64'(load_done_o), pendingDone ? 64'(ohBank(pendBank)) : 64'(0));
    checkOutput("last_n",    64'(load_n_o),    pendingDone ? 64'(pendN) : 64'(0));
    checkOutput("last_err",  64'(load_err_o),  pendingDone ? 64'(pendErr) : 64'(0));
    pendingDone = 1'b0;
  endtask

  initial begin
    in_vld     = 1'b0;
    in_w       = '0;
    in_last    = 1'b0;
    bankStatus = '0;
    rst        = 1'b0;
    #3;
    resetDut(1'b0);

    applyStimulus(5,  0, 0, 1'b1);
    applyStimulus(16, 0, 0, 1'b0);
    applyStimulus(18, 1, 0, 1'b0);
    applyStimulus(1,  3, 0, 1'b0);
    applyStimulus(1,  0, 0, 1'b0);
    applyStimulus(2,  0, 0, 1'b0);
    applyStimulus(8,  0, 3, 1'b0);
    applyStimulus(4,  0, 0, 1'b1);

    for (int p = 0; p < 30; p++) begin
      if (p == 12) applyStimulus(9, int'($urandom_range(0, 2)), 3, 1'b0);
      else applyStimulus(int'($urandom_range(1, N + 3)),
                         int'($urandom_range(0, 3)), 0, 1'b0);
    end
    flushReport();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
